vga_bounce_box: RTL and testbench
=================================

# vga_bounce_box

Pixel source feeding `vga_sync`: takes the live pixel coordinates `px`/`py` and drives its 30-bit `iRGB` input. Renders a solid box over a constant background. Moves the box once per frame during vertical blank and bounces it off the 640x480 visible edges. Cycles the box colour on every bounce frame. Produces a registered one-cycle-late colour stream plus status outputs for test and debug.

## Interface
Parameters:
- `H_PIXELS`, 640 — visible width
- `V_PIXELS`, 480 — visible height
- `BOX_W`, 32 — box width in pixels
- `BOX_H`, 32 — box height in pixels
- `STEP`, 2 — pixels moved per frame on each axis; must satisfy 1..min(BOX_W, BOX_H)
- `X0`, 0 — reset x position
- `Y0`, 0 — reset y position
- `BG_RGB`, 30'h0 — background colour, {R[9:0], G[9:0], B[9:0]}

Ports:
- `iCLK`  in  1  — pixel clock, 25 MHz
- `iRST`  in  1  — reset; synchronous, active-high. Single clock domain.
- `iEN`  in  1  — motion enable; low freezes the box
- `iPX`  in  10  — current pixel x, from `vga_sync` `px`
- `iPY`  in  10  — current pixel y, from `vga_sync` `py`
- `oRGB`  out  30  — pixel colour, to `vga_sync` `iRGB`
- `oBOX_X`  out  10  — box left edge
- `oBOX_Y`  out  10  — box top edge
- `oCOLOR_IDX`  out  3  — current box colour index
- `oFRAME_TICK`  out  1  — one-cycle pulse at start of vertical blank
- `oFRAME_CNT`  out  16  — frames since sync, wraps

## Operation
- **Frame tick:** register `py_d` (reset 0). Tick = (`iPY` == V_PIXELS) && (`py_d` != V_PIXELS). Exactly one per frame with `vga_sync` timing.
- **State machine:**
  - WAIT_SYNC (reset state): no motion. On tick → RUN if `iEN`, else HOLD. The tick that exits WAIT_SYNC does not move the box and does not count.
  - RUN: on each tick, update position and colour and increment `oFRAME_CNT`. If `iEN` is low in any cycle → HOLD.
  - HOLD: ticks increment `oFRAME_CNT` only; position and colour frozen. If `iEN` is high → RUN.
- **Motion:** XMAX = H_PIXELS − BOX_W; YMAX = V_PIXELS − BOX_H. Direction flags `dx`/`dy` (1 = right/down) reset to 1.
  - Right: if x + STEP >= XMAX, then x = XMAX, `dx` = 0, hit. Else x += STEP.
  - Left: if x <= STEP, then x = 0, `dx` = 1, hit. Else x −= STEP.
  - Y axis is identical using YMAX and `dy`.
  - Compare in 11 bits; no underflow or overflow is permitted.
- **Colour:** `oCOLOR_IDX` increments (mod 8) once per tick on which any hit occurs. A simultaneous x+y corner hit counts once.
  - Box colour: idx 0 = white (all 3FF).
  - Otherwise R = idx[2] ? 3FF : 0, G = idx[1] ? 3FF : 0, B = idx[0] ? 3FF : 0.
- **Render:** inside = (iPX >= x) && (iPX < x + BOX_W) && (iPY >= y) && (iPY < y + BOX_H) && (iPX < H_PIXELS) && (iPY < V_PIXELS). `oRGB` <= inside ? box colour : BG_RGB.
- **Reset values:** `oRGB` 0; `oBOX_X` X0; `oBOX_Y` Y0; `dx`/`dy` 1; `oCOLOR_IDX` 0; `oFRAME_TICK` 0; `oFRAME_CNT` 0; state WAIT_SYNC.

## Timing
- `oRGB` is registered: colour for coordinate (iPX, iPY) appears one cycle later. The box therefore displays one pixel right of `oBOX_X`; top level accepts this.
- `oFRAME_TICK` is registered: high during the cycle after the `iPY` transition to V_PIXELS.
- Position, direction, colour and frame count update in that same cycle, so new values are visible the cycle after the tick pulse. This falls in vertical blank, so no tearing.
- `iEN` is sampled every cycle. `iEN` changing on the tick cycle: the state before the edge decides whether that tick moves the box.
- `iRST` asserted mid-frame: all state returns to reset values on the next edge. The next tick only re-syncs (WAIT_SYNC rule).
- If `iPY` already equals V_PIXELS when reset releases, a tick fires on the first cycle. This is accepted as the sync tick.
- Input coordinates outside the visible area always yield BG_RGB, including counts up to 799/524.

## Test plan
- **Reset:** hold `iRST` 3 cycles with `iEN`=1, drive real `vga_sync` timing → `oBOX_X`=0, `oBOX_Y`=0, `oRGB`=0, `oFRAME_CNT`=0. First tick leaves position at (0,0); second tick → (2,2), `oFRAME_CNT`=1.
- **Render edges:** box at (100,50), white. Pixels (100,50) and (131,81) → 30'h3FFFFFFF one cycle later. Pixels (99,50), (132,50) and (100,82) → BG_RGB.
- **Right-wall bounce:** defaults, force x=606 moving right → next tick x=608, `dx`=0, `oCOLOR_IDX` 0→1. Following tick x=606.
- **Corner hit:** x=606, y=446, both moving positive → (608,448), both flags flip, `oCOLOR_IDX` increments by exactly 1.
- **Hold:** `iEN`=0 for 5 frames → position and colour unchanged, `oFRAME_CNT` +5. Re-enable → next tick moves by STEP.
- **Mid-frame reset:** assert `iRST` at `iPY`=200 while at (300,120) → reset values next cycle. First following tick causes no motion.

Source files
------------

// File: rtl/vga_bounce_box.sv
// Pixel source for vga_sync: a solid box over a constant background that moves once per
// frame during vertical blank, bounces off the visible edges and changes colour on each bounce.
module vga_bounce_box #(
  parameter int          H_PIXELS = 640,
  parameter int          V_PIXELS = 480,
  parameter int          BOX_W    = 32,
  parameter int          BOX_H    = 32,
  parameter int          STEP     = 2,
  parameter int          X0       = 0,
  parameter int          Y0       = 0,
  parameter logic [29:0] BG_RGB   = 30'h0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [9:0]  iPX,
  input  logic [9:0]  iPY,
  output logic [29:0] oRGB,
  output logic [9:0]  oBOX_X,
  output logic [9:0]  oBOX_Y,
  output logic [2:0]  oCOLOR_IDX,
  output logic        oFRAME_TICK,
  output logic [15:0] oFRAME_CNT
);

  localparam logic [10:0] XMAX   = 11'(H_PIXELS - BOX_W);
  localparam logic [10:0] YMAX   = 11'(V_PIXELS - BOX_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] BW11   = 11'(BOX_W);
  localparam logic [10:0] BH11   = 11'(BOX_H);
  localparam logic [10:0] HP11   = 11'(H_PIXELS);
  localparam logic [10:0] VP11   = 11'(V_PIXELS);
  localparam logic [9:0]  VP10   = 10'(V_PIXELS);
  localparam logic [9:0]  X0_10  = 10'(X0);
  localparam logic [9:0]  Y0_10  = 10'(Y0);

  typedef enum logic [1:0] {WAIT_SYNC, RUN, HOLD} state_t;

  state_t      state, state_n;
  logic [9:0]  py_d;
  logic        dx, dy;
  logic        tick_p0;
  logic        move, count;
  logic [11:0] xr, yr;
  logic        hit;
  logic        inside_p0;
  logic [10:0] px11, py11, bx11, by11;

  // One axis step: returns {hit, new direction, new position}. All compares in 11 bits.
  function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] sum, dif;
    sum = pos + STEP11;
    dif = pos - STEP11;
    if (dir) begin
      if (sum >= lim) step_axis = {1'b1, 1'b0, lim[9:0]};
      else            step_axis = {1'b0, 1'b1, sum[9:0]};
    end else begin
      if (pos <= STEP11) step_axis = {1'b1, 1'b1, 10'd0};
      else               step_axis = {1'b0, 1'b0, dif[9:0]};
    end
  endfunction

  // Index 0 is white; otherwise each index bit enables one full-scale channel.
  function automatic logic [29:0] box_color(input logic [2:0] idx);
    if (idx == 3'd0) box_color = {30{1'b1}};
    else             box_color = {{10{idx[2]}}, {10{idx[1]}}, {10{idx[0]}}};
  endfunction

  assign tick_p0 = (iPY == VP10) && (py_d != VP10);

  assign px11 = {1'b0, iPX};
  assign py11 = {1'b0, iPY};
  assign bx11 = {1'b0, oBOX_X};
  assign by11 = {1'b0, oBOX_Y};

  assign inside_p0 = (px11 >= bx11) && (px11 < bx11 + BW11) &&
                     (py11 >= by11) && (py11 < by11 + BH11) &&
                     (px11 < HP11) && (py11 < VP11);

  assign xr  = step_axis(bx11, dx, XMAX);
  assign yr  = step_axis(by11, dy, YMAX);
  assign hit = xr[11] | yr[11];

  always_comb begin
    state_n = state;
    move    = 1'b0;
    count   = 1'b0;
    case (state)
      WAIT_SYNC: if (oFRAME_TICK) state_n = iEN ? RUN : HOLD;
      RUN: begin
        if (oFRAME_TICK) begin
          move  = 1'b1;
          count = 1'b1;
        end
        if (!iEN) state_n = HOLD;
      end
      HOLD: begin
        if (oFRAME_TICK) count = 1'b1;
        if (iEN) state_n = RUN;
      end
      default: state_n = WAIT_SYNC;
    endcase
  end

  // Stage p0 -> p1: registered tick, colour stream and per-frame motion state.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= WAIT_SYNC;
      py_d        <= 10'd0;
      oFRAME_TICK <= 1'b0;
      oRGB        <= 30'd0;
      oBOX_X      <= X0_10;
      oBOX_Y      <= Y0_10;
      dx          <= 1'b1;
      dy          <= 1'b1;
      oCOLOR_IDX  <= 3'd0;
      oFRAME_CNT  <= 16'd0;
    end else begin
      state       <= state_n;
      py_d        <= iPY;
      oFRAME_TICK <= tick_p0;
      oRGB        <= inside_p0 ? box_color(oCOLOR_IDX) : BG_RGB;
      if (move) begin
        oBOX_X <= xr[9:0];
        dx     <= xr[10];
        oBOX_Y <= yr[9:0];
        dy     <= yr[10];
        if (hit) oCOLOR_IDX <= oCOLOR_IDX + 3'd1;
      end
      if (count) oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: abbreviated frames drive the tick, four instances
// with different start positions cover render edges, wall and corner bounces.
module tb_vga_bounce_box;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [9:0]  px, py;

  logic [29:0] rgb,  r_rgb,  w_rgb,  c_rgb;
  logic [9:0]  bx,   r_bx,   w_bx,   c_bx;
  logic [9:0]  by,   r_by,   w_by,   c_by;
  logic [2:0]  idx,  r_idx,  w_idx,  c_idx;
  logic        tick, r_tick, w_tick, c_tick;
  logic [15:0] cnt,  r_cnt,  w_cnt,  c_cnt;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  vga_bounce_box dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPX(px), .iPY(py),
    .oRGB(rgb), .oBOX_X(bx), .oBOX_Y(by), .oCOLOR_IDX(idx),
    .oFRAME_TICK(tick), .oFRAME_CNT(cnt));

  vga_bounce_box #(.X0(100), .Y0(50), .BG_RGB(30'h12345678)) dut_r (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPX(px), .iPY(py),
    .oRGB(r_rgb), .oBOX_X(r_bx), .oBOX_Y(r_by), .oCOLOR_IDX(r_idx),
    .oFRAME_TICK(r_tick), .oFRAME_CNT(r_cnt));

  vga_bounce_box #(.X0(606), .Y0(100)) dut_w (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPX(px), .iPY(py),
    .oRGB(w_rgb), .oBOX_X(w_bx), .oBOX_Y(w_by), .oCOLOR_IDX(w_idx),
    .oFRAME_TICK(w_tick), .oFRAME_CNT(w_cnt));

  vga_bounce_box #(.X0(606), .Y0(446)) dut_c (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPX(px), .iPY(py),
    .oRGB(c_rgb), .oBOX_X(c_bx), .oBOX_Y(c_by), .oCOLOR_IDX(c_idx),
    .oFRAME_TICK(c_tick), .oFRAME_CNT(c_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short frame: iPY enters V_PIXELS, tick pulses one cycle, motion lands on the next edge.
  task automatic frame();
    py = 10'd0;
    step();
    py = 10'd480;
    step();
    check("tick_high", {31'd0, tick}, 32'd1);
    step();
    check("tick_low", {31'd0, tick}, 32'd0);
    py = 10'd0;
    step();
  endtask

  task automatic pixel(input int x, input int y);
    px = 10'(x);
    py = 10'(y);
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; px = 10'd0; py = 10'd0;
    repeat (3) step();
    check("rst_x",   {22'd0, bx},  32'd0);
    check("rst_y",   {22'd0, by},  32'd0);
    check("rst_rgb", {2'd0, rgb},  32'd0);
    check("rst_cnt", {16'd0, cnt}, 32'd0);
    check("rst_idx", {29'd0, idx}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_wx",  {22'd0, w_bx}, 32'd606);
    rst = 1'b0;

    pixel(100, 50);  check("r_tl",    {2'd0, r_rgb}, 32'h3FFFFFFF);
    pixel(131, 81);  check("r_br",    {2'd0, r_rgb}, 32'h3FFFFFFF);
    pixel(99, 50);   check("r_left",  {2'd0, r_rgb}, 32'h12345678);
    pixel(132, 50);  check("r_right", {2'd0, r_rgb}, 32'h12345678);
    pixel(100, 82);  check("r_below", {2'd0, r_rgb}, 32'h12345678);
    pixel(0, 0);     check("d_origin", {2'd0, rgb}, 32'h3FFFFFFF);
    pixel(32, 0);    check("d_right",  {2'd0, rgb}, 32'h0);
    pixel(700, 50);  check("r_offscreen", {2'd0, r_rgb}, 32'h12345678);
    px = 10'd0;

    frame();
    check("sync_x",   {22'd0, bx},  32'd0);
    check("sync_y",   {22'd0, by},  32'd0);
    check("sync_cnt", {16'd0, cnt}, 32'd0);
    check("sync_wx",  {22'd0, w_bx}, 32'd606);

    frame();
    check("f1_x",   {22'd0, bx},  32'd2);
    check("f1_y",   {22'd0, by},  32'd2);
    check("f1_cnt", {16'd0, cnt}, 32'd1);
    check("w_hit_x",   {22'd0, w_bx}, 32'd608);
    check("w_hit_y",   {22'd0, w_by}, 32'd102);
    check("w_hit_idx", {29'd0, w_idx}, 32'd1);
    check("c_hit_x",   {22'd0, c_bx}, 32'd608);
    check("c_hit_y",   {22'd0, c_by}, 32'd448);
    check("c_hit_idx", {29'd0, c_idx}, 32'd1);

    frame();
    check("f2_x",   {22'd0, bx},  32'd4);
    check("f2_cnt", {16'd0, cnt}, 32'd2);
    check("w_back_x", {22'd0, w_bx}, 32'd606);
    check("w_back_y", {22'd0, w_by}, 32'd104);
    check("w_idx_keep", {29'd0, w_idx}, 32'd1);
    check("c_back_x", {22'd0, c_bx}, 32'd606);
    check("c_back_y", {22'd0, c_by}, 32'd446);
    check("c_idx_keep", {29'd0, c_idx}, 32'd1);

    en = 1'b0;
    step();
    repeat (5) frame();
    check("hold_x",   {22'd0, bx},  32'd4);
    check("hold_y",   {22'd0, by},  32'd4);
    check("hold_cnt", {16'd0, cnt}, 32'd7);
    check("hold_idx", {29'd0, idx}, 32'd0);
    check("hold_wx",  {22'd0, w_bx}, 32'd606);
    check("hold_widx", {29'd0, w_idx}, 32'd1);

    en = 1'b1;
    step();
    frame();
    check("resume_x",   {22'd0, bx},  32'd6);
    check("resume_y",   {22'd0, by},  32'd6);
    check("resume_cnt", {16'd0, cnt}, 32'd8);
    check("resume_wx",  {22'd0, w_bx}, 32'd604);
    check("resume_wy",  {22'd0, w_by}, 32'd106);
    check("resume_cx",  {22'd0, c_bx}, 32'd604);
    check("resume_cy",  {22'd0, c_by}, 32'd444);

    pixel(604, 106); check("w_blue", {2'd0, w_rgb}, 32'h000003FF);

    py = 10'd200;
    rst = 1'b1;
    step();
    check("mrst_x",   {22'd0, bx},  32'd0);
    check("mrst_y",   {22'd0, by},  32'd0);
    check("mrst_cnt", {16'd0, cnt}, 32'd0);
    check("mrst_rgb", {2'd0, rgb},  32'd0);
    check("mrst_widx", {29'd0, w_idx}, 32'd0);
    rst = 1'b0;

    frame();
    check("mrst_sync_x",   {22'd0, bx},  32'd0);
    check("mrst_sync_cnt", {16'd0, cnt}, 32'd0);
    frame();
    check("mrst_move_x",   {22'd0, bx},  32'd2);
    check("mrst_move_cnt", {16'd0, cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
